// File: rtl/gfx_cmd_tx_if.sv
// Draw-request port of the graphics command transmitter: valid/ready plus the
// request fields. Master is the requester, slave is gfx_cmd_tx.
interface gfx_cmd_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [7:0] req_xs;
  logic [7:0] req_ys;
  logic [7:0] req_xe;
  logic [7:0] req_ye;
  logic [7:0] req_colour;

  modport master (
    output req_valid, req_op, req_xs, req_ys, req_xe, req_ye, req_colour,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_op, req_xs, req_ys, req_xe, req_ye, req_colour,
    output req_ready
  );
endinterface

// File: rtl/gfx_cmd_tx.sv
// Graphics command transmitter: FIFOs point/line requests and serialises them as
// opcode+operand bytes, then guards the stream. GFX_TX_BUSY_HANDSHAKE_EN adds eng_busy.
module gfx_cmd_tx #(
  parameter int         DEPTH       = 4,
  parameter int         GUARD_BASE  = 16,
  parameter int         GUARD_PER_X = 4,
  parameter logic [7:0] IDLE_BYTE   = 8'h00
) (
  input  logic         clk,
  input  logic         rst,
  gfx_cmd_tx_if.slave  rq,
  output logic [7:0]   cmd,
  output logic         cmd_strobe,
  output logic         busy
`ifdef GFX_TX_BUSY_HANDSHAKE_EN
  , input  logic       eng_busy
`endif
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic       op;
    logic [7:0] xs;
    logic [7:0] ys;
    logic [7:0] xe;
    logic [7:0] ye;
    logic [7:0] colour;
  } req_t;

  typedef enum logic [1:0] {IDLE, SEND, GUARD} state_t;

  req_t          mem [DEPTH];
  req_t          in_req, head, pkt;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, pop;
  state_t        state;
  logic [2:0]    idx, pkt_len;
  logic [15:0]   gcnt, guard_ld;
  logic [8:0]    dx;
  logic [7:0]    nxt_byte;
  logic          guard_rel;

  assign in_req       = '{op: rq.req_op, xs: rq.req_xs, ys: rq.req_ys,
                          xe: rq.req_xe, ye: rq.req_ye, colour: rq.req_colour};
  assign rq.req_ready = (count != (AW+1)'(DEPTH));
  assign push         = rq.req_valid & rq.req_ready;
  assign pop          = (state == IDLE) && (count != '0);
  assign head         = mem[rptr];
  assign busy         = (count != '0) || (state != IDLE);

  always_ff @(posedge clk)
    if (push) mem[wptr] <= in_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // idx names the next operand byte to drive; the opcode leaves on the pop edge.
  always_comb begin
    pkt_len  = pkt.op ? 3'd6 : 3'd4;
    nxt_byte = IDLE_BYTE;
    case (idx)
      3'd1:    nxt_byte = pkt.xs;
      3'd2:    nxt_byte = pkt.ys;
      3'd3:    nxt_byte = pkt.op ? pkt.xe : pkt.colour;
      3'd4:    nxt_byte = pkt.ye;
      3'd5:    nxt_byte = pkt.colour;
      default: nxt_byte = IDLE_BYTE;
    endcase
  end

  // The engine only walks x upwards, so a reversed line costs a single x step.
  always_comb begin
    dx = (pkt.xe >= pkt.xs) ? ({1'b0, pkt.xe} - {1'b0, pkt.xs}) : 9'd0;
`ifdef GFX_TX_BUSY_HANDSHAKE_EN
    guard_ld  = 16'd2;
    guard_rel = !eng_busy;
`else
    guard_ld  = pkt.op ? 16'(GUARD_BASE) + 16'(GUARD_PER_X) * (16'(dx) + 16'd1)
                       : 16'(GUARD_BASE);
    guard_rel = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd        <= IDLE_BYTE;
      cmd_strobe <= 1'b0;
      idx        <= '0;
      gcnt       <= '0;
      pkt        <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          pkt        <= head;
          idx        <= 3'd1;
          cmd        <= head.op ? 8'd76 : 8'd80;
          cmd_strobe <= 1'b1;
          state      <= SEND;
        end
        SEND: if (idx == pkt_len) begin
          cmd        <= IDLE_BYTE;
          cmd_strobe <= 1'b0;
          idx        <= '0;
          gcnt       <= guard_ld;
          state      <= GUARD;
        end else begin
          cmd <= nxt_byte;
          idx <= idx + 3'd1;
        end
        GUARD: if (gcnt > 16'd1) gcnt <= gcnt - 16'd1;
          else if (guard_rel) begin
            gcnt  <= '0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gfx_cmd_tx.sv
// Scoreboard bench for gfx_cmd_tx: requests push expected packets with their
// accept edge; a negedge monitor checks bytes, start cycle, idle gaps, ready and busy.
module tb_gfx_cmd_tx;
  localparam int         DEPTH       = 4;
  localparam int         GUARD_BASE  = 16;
  localparam int         GUARD_PER_X = 4;
  localparam logic [7:0] IDLE_BYTE   = 8'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cmd;
  logic       cmd_strobe, busy;
`ifdef GFX_TX_BUSY_HANDSHAKE_EN
  logic       eng_busy = 1'b0;
`endif

  gfx_cmd_tx_if rq ();

  gfx_cmd_tx #(.DEPTH(DEPTH), .GUARD_BASE(GUARD_BASE), .GUARD_PER_X(GUARD_PER_X),
               .IDLE_BYTE(IDLE_BYTE)) dut (
    .clk        (clk),
    .rst        (rst),
    .rq         (rq.slave),
    .cmd        (cmd),
    .cmd_strobe (cmd_strobe),
    .busy       (busy)
`ifdef GFX_TX_BUSY_HANDSHAKE_EN
    , .eng_busy (eng_busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int              len;
    logic [5:0][7:0] b;
    longint          g;
    longint          acc;
  } exp_t;

  exp_t   exp_q[$];
  longint cyc = 0;
  int     n_chk = 0, n_fail = 0;
  bit     mon_en = 1'b0;
  int     idx = 0;
  exp_t   cur;
  longint prev_last = -100000;
  longint prev_g = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference packet: bytes from the opcode table, guard from the dx rule.
  function automatic exp_t model(input bit op, input logic [7:0] xs, ys, xe, ye, col);
    exp_t e;
    int   d;
    e.b = '0;
    if (op) begin
      e.len = 6;
      e.b[0] = 8'd76; e.b[1] = xs; e.b[2] = ys; e.b[3] = xe; e.b[4] = ye; e.b[5] = col;
      d = (int'(xe) >= int'(xs)) ? int'(xe) - int'(xs) : 0;
      e.g = GUARD_BASE + GUARD_PER_X * (d + 1);
    end else begin
      e.len = 4;
      e.b[0] = 8'd80; e.b[1] = xs; e.b[2] = ys; e.b[3] = col;
      e.g = GUARD_BASE;
    end
`ifdef GFX_TX_BUSY_HANDSHAKE_EN
    e.g = 2;
`endif
    e.acc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!mon_en) begin
      idx = 0;
      prev_last = -100000;
      prev_g = 0;
      exp_q.delete();
    end else begin
      int     cnt;
      longint st;
      if (cmd_strobe) begin
        if (idx == 0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
            idx = -1;
          end else begin
            cur = exp_q.pop_front();
            st = cur.acc + 1;
            if (prev_last + prev_g + 2 > st) st = prev_last + prev_g + 2;
            chk("start_cycle", cyc, st);
          end
        end
        if (idx >= 0) begin
          chk("byte", cmd, cur.b[idx]);
          idx++;
          if (idx == cur.len) begin
            idx = 0;
            prev_last = cyc;
            prev_g = cur.g;
          end
        end else idx = 0;
      end else begin
        chk("idle_byte", cmd, IDLE_BYTE);
        if (idx != 0) begin
          chk("gap_in_packet", idx, 0);
          idx = 0;
        end
      end
      cnt = 0;
      foreach (exp_q[i]) if (exp_q[i].acc <= cyc) cnt++;
      chk("req_ready", rq.req_ready, cnt < DEPTH);
      chk("busy", busy, cmd_strobe || (cyc <= prev_last + prev_g) || cnt > 0);
    end
  end

  task automatic send(input bit op, input logic [7:0] xs, ys, xe, ye, col);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    rq.req_valid = 1'b1; rq.req_op = op;
    rq.req_xs = xs; rq.req_ys = ys; rq.req_xe = xe; rq.req_ye = ye; rq.req_colour = col;
    while (!rq.req_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) chk("ready_timeout", n, 0);
    else begin
      e = model(op, xs, ys, xe, ye, col);
      e.acc = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic drop();
    @(negedge clk);
    rq.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || cyc <= prev_last + prev_g + 1) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rq.req_valid = 1'b0; rq.req_op = 1'b0;
    rq.req_xs = '0; rq.req_ys = '0; rq.req_xe = '0; rq.req_ye = '0; rq.req_colour = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_cmd", cmd, IDLE_BYTE);
    chk("reset_strobe", cmd_strobe, 0);
    chk("reset_ready", rq.req_ready, 1);
    chk("reset_busy", busy, 0);
    @(posedge clk); #1 mon_en = 1'b1;

    send(0, 8'h0A, 8'h14, 8'h00, 8'h00, 8'h3F); drop(); drain();
    send(1, 8'h02, 8'h03, 8'h05, 8'h04, 8'h07); drop(); drain();
    send(1, 8'h09, 8'h00, 8'h03, 8'h01, 8'h55); drop(); drain();
    send(1, 8'h00, 8'h01, 8'hFF, 8'h02, 8'h11); drop(); drain();

    // Six requests with valid held: the FIFO fills and ready must drop.
    for (int i = 0; i < 6; i++)
      send(i[0], 8'(i * 3), 8'(i), 8'(i * 3 + i), 8'(i + 1), 8'(8'hA0 + i));
    drop(); drain();

    for (int i = 0; i < 25; i++) begin
      logic [7:0] xs, xe;
      xs = 8'($urandom_range(0, 255));
      xe = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                       : 8'(xs + 8'($urandom_range(0, 12)));
      send(1'($urandom_range(0, 1)), xs, 8'($urandom_range(0, 255)), xe,
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) begin
        drop();
        repeat ($urandom_range(1, 40)) @(negedge clk);
      end
    end
    drop(); drain();

    // Reset while the third byte of a line is on cmd.
    send(1, 8'h20, 8'h21, 8'h30, 8'h22, 8'h33); drop();
    n = 0;
    while (!(cmd_strobe && cmd == 8'd76) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("line_opcode_seen", n < 100, 1);
    @(posedge clk); @(posedge clk);
    #1 mon_en = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_cmd", cmd, IDLE_BYTE);
    chk("midrst_strobe", cmd_strobe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", rq.req_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1 mon_en = 1'b1;
    send(0, 8'h05, 8'h06, 8'h00, 8'h00, 8'h77); drop(); drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
